platform_row_fetcher: RTL and testbench



---
 rtl/platform_pkg.sv | 24 ++
 rtl/row_line_buffer.sv | 25 ++
 rtl/platform_row_fetcher.sv | 122 ++++++++++++
 tb/tb_platform_row_fetcher.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/platform_pkg.sv
// rtl/platform_pkg.sv - shared types and constants for the platform block row fetcher
package platform_pkg;

    localparam int TILE_W = 16;
    localparam int IDX_W  = $clog2(TILE_W);
    localparam int ROM_AW = 8;
    localparam int PIX_W  = 24;
    localparam logic [PIX_W-1:0] KEY_COLOR = 24'hFF00FF;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } fetch_state_t;

    // Mirroring reverses the column order within a power-of-two row.
    function automatic logic [IDX_W-1:0] col_of(input logic [IDX_W-1:0] k, input logic mirror);
        return mirror ? ~k : k;
    endfunction

endpackage

// File: rtl/row_line_buffer.sv
// rtl/row_line_buffer.sv - one-row pixel store with combinational read and transparency flag
module row_line_buffer
    import platform_pkg::*;
(
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  pixel_t           wdata_i,
    input  logic [IDX_W-1:0] raddr_i,
    output pixel_t           rdata_o,
    output logic             opaque_o
);

    pixel_t mem_q [TILE_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign opaque_o = (rdata_o != KEY_COLOR);

endmodule

// File: rtl/platform_row_fetcher.sv
// rtl/platform_row_fetcher.sv - fetches one block row from the sprite ROM into a line buffer
module platform_row_fetcher
    import platform_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [IDX_W-1:0]  row,
    input  logic              mirror,
    output logic              busy,
    output logic              done,
    output logic              buf_valid,
    output logic [ROM_AW-1:0] rom_addr,
    input  pixel_t            rom_data,
    input  logic [IDX_W-1:0]  pix_idx,
    output pixel_t            pix_data,
    output logic              pix_opaque
);

    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(TILE_W - 1);

    fetch_state_t      state_q, state_d;
    logic [IDX_W-1:0]  row_q, row_d;
    logic              mirror_q, mirror_d;
    logic [IDX_W-1:0]  ic_q, ic_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]  s1_k_q, s1_k_d;
    logic              s2_valid_q;
    logic [IDX_W-1:0]  s2_k_q;
    logic              done_q, done_d;
    logic              buf_valid_q, buf_valid_d;

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        mirror_d    = mirror_q;
        ic_d        = ic_q;
        rom_addr_d  = rom_addr_q;
        s1_valid_d  = 1'b0;
        s1_k_d      = ic_q;
        done_d      = 1'b0;
        buf_valid_d = buf_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    row_d       = row;
                    mirror_d    = mirror;
                    ic_d        = IDX_W'(1);
                    rom_addr_d  = {row, col_of('0, mirror)};
                    s1_valid_d  = 1'b1;
                    s1_k_d      = '0;
                    buf_valid_d = 1'b0;
                    state_d     = FETCH;
                end
            end
            FETCH: begin
                rom_addr_d = {row_q, col_of(ic_q, mirror_q)};
                s1_valid_d = 1'b1;
                s1_k_d     = ic_q;
                ic_d       = ic_q + IDX_W'(1);
                if (ic_q == LAST_K) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (s2_valid_q && (s2_k_q == LAST_K)) begin
                    done_d      = 1'b1;
                    buf_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            ic_q        <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            mirror_q    <= mirror_d;
            ic_q        <= ic_d;
            rom_addr_q  <= rom_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_k_q      <= s1_k_d;
            s2_valid_q  <= s1_valid_q;
            s2_k_q      <= s1_k_q;
            done_q      <= done_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    // Stage 2 lines up with rom_data; a reset edge drops whatever is in flight.
    row_line_buffer u_line_buf (
        .clk_i    (Clk),
        .we_i     (s2_valid_q & ~Reset),
        .waddr_i  (s2_k_q),
        .wdata_i  (rom_data),
        .raddr_i  (pix_idx),
        .rdata_o  (pix_data),
        .opaque_o (pix_opaque)
    );

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign buf_valid = buf_valid_q;
    assign rom_addr  = rom_addr_q;

endmodule

// File: tb/tb_platform_row_fetcher.sv
// tb/tb_platform_row_fetcher.sv - randomized self-checking bench for platform_row_fetcher
module tb_platform_row_fetcher;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        start;
    logic [3:0]  row;
    logic        mirror;
    logic        busy;
    logic        done;
    logic        buf_valid;
    logic [7:0]  rom_addr;
    logic [23:0] rom_data;
    logic [3:0]  pix_idx;
    logic [23:0] pix_data;
    logic        pix_opaque;

    logic [23:0] mem [256];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    always @(posedge Clk) rom_data <= mem[rom_addr];

    platform_row_fetcher dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .start      (start),
        .row        (row),
        .mirror     (mirror),
        .busy       (busy),
        .done       (done),
        .buf_valid  (buf_valid),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pix_idx    (pix_idx),
        .pix_data   (pix_data),
        .pix_opaque (pix_opaque)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Model: after a fetch, buffer[k] is the ROM word at row*16 + (mirror ? 15-k : k).
    task automatic do_fetch(input logic [3:0] r, input logic m, input bit poke);
        logic [23:0] exp_buf [16];
        for (int k = 0; k < 16; k++) begin
            exp_buf[k] = mem[int'(r) * 16 + (m ? 15 - k : k)];
        end
        start  = 1'b1;
        row    = r;
        mirror = m;
        step();
        start  = 1'b0;
        for (int c = 0; c < 18; c++) begin
            if (c < 16) check("addr", 32'(rom_addr), 32'(int'(r) * 16 + (m ? 15 - c : c)));
            check("done", 32'(done), 32'(c == 17));
            check("busy", 32'(busy), 32'd1);
            check("buf_valid", 32'(buf_valid), 32'(c == 17));
            row     = 4'($urandom);
            mirror  = 1'($urandom);
            pix_idx = 4'($urandom);
            start   = poke && (c == 5 || c == 17);
            step();
        end
        start = 1'b0;
        check("busy_end", 32'(busy), 32'd0);
        check("done_end", 32'(done), 32'd0);
        check("buf_valid_end", 32'(buf_valid), 32'd1);
        for (int k = 0; k < 16; k++) begin
            pix_idx = 4'(k);
            #1;
            check("pix_data", 32'(pix_data), 32'(exp_buf[k]));
            check("pix_opaque", 32'(pix_opaque), 32'(exp_buf[k] != 24'hFF00FF));
        end
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {16'h0, 8'(i)};
        Reset   = 1'b1;
        start   = 1'b0;
        row     = '0;
        mirror  = 1'b0;
        pix_idx = '0;
        repeat (3) step();
        Reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_bvalid", 32'(buf_valid), 32'd0);
            check("rst_addr", 32'(rom_addr), 32'd0);
            step();
        end

        do_fetch(4'd3, 1'b0, 1'b0);
        do_fetch(4'd15, 1'b1, 1'b0);
        do_fetch(4'd7, 1'b0, 1'b1);
        do_fetch(4'd8, 1'b1, 1'b0);

        start  = 1'b1;
        row    = 4'd5;
        mirror = 1'b0;
        step();
        start = 1'b0;
        repeat (9) step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_bvalid", 32'(buf_valid), 32'd0);
        for (int c = 0; c < 20; c++) begin
            check("abort_nodone", 32'(done), 32'd0);
            step();
        end
        do_fetch(4'd1, 1'b0, 1'b0);

        mem[8'h22] = 24'hFF00FF;
        do_fetch(4'd2, 1'b0, 1'b0);

        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < 256; i++) begin
                mem[i] = ($urandom_range(0, 7) == 0) ? 24'hFF00FF : 24'($urandom);
            end
            do_fetch(4'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
